// File: rtl/c1_bus_arbiter_pkg.sv
// Shared widths, C1 command encodings and sequencer states for the bus1
// two-requester arbiter.
package c1_bus_arbiter_pkg;

  localparam int TAGSET_W = 10;
  localparam int OFFSET_W = 4;
  localparam int ADDR_W   = TAGSET_W + OFFSET_W;
  localparam int DATA_W   = 16;
  localparam int CTR_W    = 3;
  localparam int TIMEOUT  = 255;
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [CTR_W-1:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_INVALIDATE_LINE = 3'd4,
    C1_WRITE8          = 3'd5,
    C1_WRITE16         = 3'd6,
    C1_RESPONSE        = 3'd7
  } c1_cmd_e;

  // WRITE32 shares its code with the cache's response tick, so a requester
  // issuing it is answered with an error instead of being sent to the bus.
  localparam logic [CTR_W-1:0] C1_WRITE32 = C1_RESPONSE;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_RESP2, S_DONE, S_ERR
  } state_e;

  function automatic logic is_write(input logic [CTR_W-1:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

endpackage

// File: rtl/c1_bus_arbiter_if.sv
// Requester-side request/response handshake for the bus1 arbiter; index 0/1
// of each packed array belongs to requester 0/1.
interface c1_bus_arbiter_if;
  import c1_bus_arbiter_pkg::*;

  logic [1:0]                     req_valid;
  logic [1:0][CTR_W-1:0]          req_cmd;
  logic [1:0][ADDR_W-1:0]         req_addr;
  logic [1:0][2*DATA_W-1:0]       req_wdata;
  logic [1:0]                     req_ready;
  logic [1:0]                     rsp_valid;
  logic [1:0]                     rsp_err;
  logic [2*DATA_W-1:0]            rsp_rdata;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/c1_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester that was not granted last.
module c1_bus_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       gnt_valid_o
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt_idx_o = 1'b0;
    unique case (req_i)
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~rr_last_q;
      default: gnt_idx_o = 1'b0;
    endcase
    gnt_valid_o = |req_i;
    gnt_o       = gnt_valid_o ? (2'b01 << gnt_idx_o) : 2'b00;
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept_i) rr_last_d = gnt_idx_o;
  end

  // Starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/c1_bus_arbiter.sv
// Bus1 arbiter/sequencer: grants one of two requesters, serialises the request
// onto A1/D1/C1, collects the cache's response ticks and returns one pulse.
module c1_bus_arbiter
  import c1_bus_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  c1_bus_arbiter_if.slave     bus_if,
  output wire  [TAGSET_W-1:0] a1_o,
  inout  wire  [DATA_W-1:0]   d1_io,
  inout  wire  [CTR_W-1:0]    c1_io,
  output logic                a1_oe_o,
  output logic                d1_oe_o,
  output logic                c1_oe_o
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [CTR_W-1:0]      cmd_q, cmd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic [1:0]            req_eff;
  logic [1:0]            gnt;
  logic                  gnt_idx, gnt_valid, accept;
  logic [CTR_W-1:0]      req_cmd_g;
  logic                  rsp_tick, tmo_hit;
  logic [TAGSET_W-1:0]   a1_drv;
  logic [DATA_W-1:0]     d1_drv;
  logic [CTR_W-1:0]      c1_drv;

  // A valid with a NOP command is not a request.
  assign req_eff[0] = bus_if.req_valid[0] && (bus_if.req_cmd[0] != C1_NOP);
  assign req_eff[1] = bus_if.req_valid[1] && (bus_if.req_cmd[1] != C1_NOP);

  c1_bus_arbiter_rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_eff),
    .accept_i    (accept),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign accept    = (state_q == S_IDLE) && gnt_valid;
  assign req_cmd_g = bus_if.req_cmd[gnt_idx];
  assign rsp_tick  = (c1_io == C1_RESPONSE);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (req_cmd_g == C1_WRITE32) ? S_ERR : S_SEND1;
      S_SEND1: state_d = S_SEND2;
      S_SEND2: state_d = S_WAIT;
      S_WAIT: begin
        if (rsp_tick)     state_d = (cmd_q == C1_READ32) ? S_RESP2 : S_DONE;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_RESP2: if (rsp_tick || tmo_hit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a1_oe_o          = 1'b0;
    d1_oe_o          = 1'b0;
    c1_oe_o          = 1'b0;
    a1_drv           = '0;
    d1_drv           = '0;
    c1_drv           = C1_NOP;
    bus_if.req_ready = 2'b00;
    bus_if.rsp_valid = 2'b00;
    bus_if.rsp_err   = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        c1_oe_o          = 1'b1;
        bus_if.req_ready = accept ? gnt : 2'b00;
      end
      S_SEND1: begin
        c1_oe_o = 1'b1;
        c1_drv  = cmd_q;
        a1_oe_o = 1'b1;
        a1_drv  = addr_q[ADDR_W-1:OFFSET_W];
        d1_oe_o = is_write(cmd_q);
        d1_drv  = wdata_q[DATA_W-1:0];
      end
      S_SEND2: begin
        c1_oe_o = 1'b1;
        c1_drv  = cmd_q;
        a1_oe_o = 1'b1;
        a1_drv  = {{(TAGSET_W-OFFSET_W){1'b0}}, addr_q[OFFSET_W-1:0]};
        d1_oe_o = (cmd_q == C1_WRITE32);
        d1_drv  = wdata_q[2*DATA_W-1:DATA_W];
      end
      S_DONE, S_ERR: begin
        c1_oe_o          = 1'b1;
        bus_if.rsp_valid = 2'b01 << owner_q;
        bus_if.rsp_err   = err_q ? (2'b01 << owner_q) : 2'b00;
      end
      default: ;
    endcase
  end

  assign a1_o             = a1_oe_o ? a1_drv : 'z;
  assign d1_io            = d1_oe_o ? d1_drv : 'z;
  assign c1_io            = c1_oe_o ? c1_drv : 'z;
  assign bus_if.rsp_rdata = rdata_q;

  always_comb begin
    owner_d = owner_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          cmd_d   = req_cmd_g;
          addr_d  = bus_if.req_addr[gnt_idx];
          wdata_d = bus_if.req_wdata[gnt_idx];
          rdata_d = '0;
          err_d   = (req_cmd_g == C1_WRITE32);
          tmo_d   = '0;
        end
      end
      S_WAIT, S_RESP2: begin
        tmo_d = tmo_q + 1'b1;
        if (rsp_tick) begin
          if (state_q == S_RESP2) begin
            rdata_d[2*DATA_W-1:DATA_W] = d1_io;
          end else begin
            unique case (cmd_q)
              C1_READ8:            rdata_d[7:0]        = d1_io[7:0];
              C1_READ16, C1_READ32: rdata_d[DATA_W-1:0] = d1_io;
              default: ;
            endcase
          end
        end else if (tmo_hit) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the whole datapath is reset so RSP_RDATA reads zero and no stale
  // owner can be pulsed after an aborted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= 1'b0;
      cmd_q   <= C1_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
